// File: rtl/predict_update_ctrl_if.sv
// Update/flush request bus and predictor-table write port shared by the
// branch-predictor update controller and whatever drives it.
interface predict_update_ctrl_if;
  logic        upd_valid1;
  logic        upd_valid2;
  logic [12:0] upd_pc1;
  logic [12:0] upd_pc2;
  logic [12:0] upd_target1;
  logic [12:0] upd_target2;
  logic        upd_taken1;
  logic        upd_taken2;
  logic        flush_req;
  logic        upd_ready;
  logic [10:0] w_addr;
  logic [15:0] w_data;
  logic        wen;
  logic        clearing;
  logic [15:0] drop_cnt;

  modport master (
    output upd_valid1, upd_valid2, upd_pc1, upd_pc2, upd_target1, upd_target2,
           upd_taken1, upd_taken2, flush_req,
    input  upd_ready, w_addr, w_data, wen, clearing, drop_cnt
  );

  modport slave (
    input  upd_valid1, upd_valid2, upd_pc1, upd_pc2, upd_target1, upd_target2,
           upd_taken1, upd_taken2, flush_req,
    output upd_ready, w_addr, w_data, wen, clearing, drop_cnt
  );
endinterface

// File: rtl/predict_update_ctrl.sv
// Queues E-stage branch updates from two pipes into a small FIFO and drains
// them one per cycle into the predictor table; clears the table on reset/flush.
module predict_update_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int N_ENTRIES  = 2048
) (
  input logic                  CLK,
  input logic                  RST,
  predict_update_ctrl_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clrCnt_q, clrCnt_d;
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [PW:0]     count_q;
  logic [15:0]     dropCnt_q;
  logic [10:0]     fifoAddr[FIFO_DEPTH];
  logic [15:0]     fifoData[FIFO_DEPTH];

  logic            updReady, acceptOk, merge, enq1, enq2, deq, flushFifo;
  logic            wenInt;
  logic [10:0]     wAddrInt;
  logic [15:0]     wDataInt;
  logic [15:0]     entry1, entry2;
  logic [1:0]      numDrop;
  logic [16:0]     dropSum;

  // Ready looks at the registered occupancy only, so a double enqueue always fits.
  assign updReady = !RST && (state_q == RUN) && (count_q <= (PW+1)'(FIFO_DEPTH - 2));
  assign acceptOk = updReady && !bus.flush_req;
  assign merge    = acceptOk && bus.upd_valid1 && bus.upd_valid2 &&
                    (bus.upd_pc1[10:0] == bus.upd_pc2[10:0]);
  assign enq1     = acceptOk && bus.upd_valid1 && !merge;
  assign enq2     = acceptOk && bus.upd_valid2;
  assign deq      = !RST && (state_q == RUN) && (count_q != '0) && !bus.flush_req;
  assign numDrop  = {1'b0, bus.upd_valid1 && !acceptOk} + {1'b0, bus.upd_valid2 && !acceptOk};
  assign dropSum  = {1'b0, dropCnt_q} + 17'(numDrop);

  assign entry1 = bus.upd_taken1 ? {1'b1, bus.upd_pc1[12:11], bus.upd_target1} : 16'h0000;
  assign entry2 = bus.upd_taken2 ? {1'b1, bus.upd_pc2[12:11], bus.upd_target2} : 16'h0000;

  always_comb begin
    state_d   = state_q;
    clrCnt_d  = clrCnt_q;
    wenInt    = 1'b0;
    wAddrInt  = 11'h000;
    wDataInt  = 16'h0000;
    flushFifo = 1'b0;
    case (state_q)
      CLEAR: begin
        wenInt   = 1'b1;
        wAddrInt = 11'(clrCnt_q);
        if (bus.flush_req) begin
          clrCnt_d = '0;
        end else if (clrCnt_q == CW'(N_ENTRIES - 1)) begin
          state_d = RUN;
        end else begin
          clrCnt_d = clrCnt_q + 1'b1;
        end
      end
      RUN: begin
        // A flush discards the queue, so the head is not written in that cycle either.
        wenInt   = (count_q != '0) && !bus.flush_req;
        wAddrInt = fifoAddr[rdPtr_q];
        wDataInt = fifoData[rdPtr_q];
        if (bus.flush_req) begin
          state_d   = CLEAR;
          clrCnt_d  = '0;
          flushFifo = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (RST) begin
      state_d   = CLEAR;
      clrCnt_d  = '0;
      wenInt    = 1'b1;
      wAddrInt  = 11'h000;
      wDataInt  = 16'h0000;
      flushFifo = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= CLEAR;
      clrCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flushFifo) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_q + PW'(enq1) + PW'(enq2);
      rdPtr_q <= rdPtr_q + PW'(deq);
      count_q <= count_q + (PW+1)'(enq1) + (PW+1)'(enq2) - (PW+1)'(deq);
    end
  end

  // Pipe 2 is younger, so it lands in the slot after pipe 1 when both enqueue.
  always_ff @(posedge CLK) begin
    if (enq1) begin
      fifoAddr[wrPtr_q] <= bus.upd_pc1[10:0];
      fifoData[wrPtr_q] <= entry1;
    end
    if (enq2) begin
      fifoAddr[wrPtr_q + PW'(enq1)] <= bus.upd_pc2[10:0];
      fifoData[wrPtr_q + PW'(enq1)] <= entry2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dropCnt_q <= 16'h0000;
    end else begin
      dropCnt_q <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
    end
  end

  assign bus.upd_ready = updReady;
  assign bus.wen       = wenInt;
  assign bus.w_addr    = wAddrInt;
  assign bus.w_data    = wDataInt;
  assign bus.clearing  = RST || (state_q == CLEAR);
  assign bus.drop_cnt  = dropCnt_q;
endmodule

// File: tb/tb_predict_update_ctrl.sv
// Directed bench for predict_update_ctrl: table of single-cycle vectors in RUN
// plus hand-written reset, clear, flush and drop-saturation sequences.
module tb_predict_update_ctrl;
  logic CLK = 1'b0;
  logic RST;

  predict_update_ctrl_if bus ();

  predict_update_ctrl #(
    .FIFO_DEPTH (4),
    .N_ENTRIES  (2048)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int vecCount = 0;
  int errCount = 0;

  typedef struct {
    logic        v1;
    logic [12:0] pc1;
    logic [12:0] tg1;
    logic        tk1;
    logic        v2;
    logic [12:0] pc2;
    logic [12:0] tg2;
    logic        tk2;
    logic        fl;
    logic        expWen;
    logic [10:0] expAddr;
    logic [15:0] expData;
    logic        expRdy;
    logic        expClr;
    logic [15:0] expDrop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic v1, input logic [12:0] pc1, input logic [12:0] tg1,
                                 input logic tk1, input logic v2, input logic [12:0] pc2,
                                 input logic [12:0] tg2, input logic tk2, input logic fl,
                                 input logic eWen, input logic [10:0] eAddr, input logic [15:0] eData,
                                 input logic eRdy, input logic eClr, input logic [15:0] eDrop);
    vec_t v;
    v.v1 = v1; v.pc1 = pc1; v.tg1 = tg1; v.tk1 = tk1;
    v.v2 = v2; v.pc2 = pc2; v.tg2 = tg2; v.tk2 = tk2;
    v.fl = fl;
    v.expWen = eWen; v.expAddr = eAddr; v.expData = eData;
    v.expRdy = eRdy; v.expClr = eClr; v.expDrop = eDrop;
    return v;
  endfunction

  function automatic vec_t idleVec(input logic eWen, input logic [10:0] eAddr, input logic [15:0] eData,
                                   input logic eRdy, input logic eClr, input logic [15:0] eDrop);
    return mkVec(1'b0, 13'h0, 13'h0, 1'b0, 1'b0, 13'h0, 13'h0, 1'b0, 1'b0,
                 eWen, eAddr, eData, eRdy, eClr, eDrop);
  endfunction

  task automatic applyStimulus(input vec_t v, input logic rst);
    RST             = rst;
    bus.upd_valid1  = v.v1;
    bus.upd_pc1     = v.pc1;
    bus.upd_target1 = v.tg1;
    bus.upd_taken1  = v.tk1;
    bus.upd_valid2  = v.v2;
    bus.upd_pc2     = v.pc2;
    bus.upd_target2 = v.tg2;
    bus.upd_taken2  = v.tk2;
    bus.flush_req   = v.fl;
  endtask

  // Address/data are only meaningful when a write is expected.
  task automatic checkOutput(input string name, input vec_t v);
    vecCount++;
    if (bus.wen !== v.expWen || bus.upd_ready !== v.expRdy || bus.clearing !== v.expClr ||
        bus.drop_cnt !== v.expDrop ||
        (v.expWen && (bus.w_addr !== v.expAddr || bus.w_data !== v.expData))) begin
      errCount++;
      $display("[TB] FAIL %s: got wen=%b addr=%h data=%h rdy=%b clr=%b drop=%h, expected wen=%b addr=%h data=%h rdy=%b clr=%b drop=%h",
               name, bus.wen, bus.w_addr, bus.w_data, bus.upd_ready, bus.clearing, bus.drop_cnt,
               v.expWen, v.expAddr, v.expData, v.expRdy, v.expClr, v.expDrop);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    @(negedge CLK);
    applyStimulus(v, 1'b0);
    #1;
    checkOutput(name, v);
  endtask

  task automatic clearCycle(input int addr, input logic [15:0] drop,
                            input logic v1, input logic v2, input logic fl);
    vec_t v;
    v = mkVec(v1, 13'h0055, 13'h0AAA, 1'b1, v2, 13'h0066, 13'h0BBB, 1'b1, fl,
              1'b1, 11'(addr), 16'h0000, 1'b0, 1'b1, drop);
    @(negedge CLK);
    applyStimulus(v, 1'b0);
    #1;
    checkOutput($sformatf("clear_addr%0d", addr), v);
  endtask

  task automatic rstCycle(input logic [15:0] drop);
    vec_t v;
    v = mkVec(1'b1, 13'h0077, 13'h0001, 1'b1, 1'b1, 13'h0078, 13'h0002, 1'b1, 1'b1,
              1'b1, 11'h000, 16'h0000, 1'b0, 1'b1, drop);
    @(negedge CLK);
    applyStimulus(v, 1'b1);
    #1;
    checkOutput("reset_outputs", v);
  endtask

  initial begin
    vec_t idle0;
    idle0 = idleVec(1'b0, 11'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    applyStimulus(idle0, 1'b1);

    // Single-cycle RUN vectors, starting with an empty FIFO and drop_cnt=2.
    vecs.push_back(mkVec(1, 13'h1ABC, 13'h0123, 1, 0, 13'h0, 13'h0, 0, 0, 0, 11'h0, 16'h0, 1, 0, 16'd2));
    vecs.push_back(idleVec(1, 11'h2BC, 16'hE123, 1, 0, 16'd2));
    vecs.push_back(idleVec(0, 11'h0, 16'h0, 1, 0, 16'd2));
    vecs.push_back(mkVec(1, 13'h0010, 13'h0005, 1, 1, 13'h0810, 13'h0007, 1, 0, 0, 11'h0, 16'h0, 1, 0, 16'd2));
    vecs.push_back(idleVec(1, 11'h010, 16'hA007, 1, 0, 16'd2));
    vecs.push_back(idleVec(0, 11'h0, 16'h0, 1, 0, 16'd2));
    vecs.push_back(mkVec(0, 13'h0, 13'h0, 0, 1, 13'h0333, 13'h1FFF, 0, 0, 0, 11'h0, 16'h0, 1, 0, 16'd2));
    vecs.push_back(idleVec(1, 11'h333, 16'h0000, 1, 0, 16'd2));
    vecs.push_back(idleVec(0, 11'h0, 16'h0, 1, 0, 16'd2));
    // Both pipes for six cycles: ready toggles, writes drain in program order.
    vecs.push_back(mkVec(1, 13'h0100, 13'h0010, 1, 1, 13'h0101, 13'h0011, 1, 0, 0, 11'h0, 16'h0, 1, 0, 16'd2));
    vecs.push_back(mkVec(1, 13'h0102, 13'h0012, 1, 1, 13'h0103, 13'h0013, 1, 0, 1, 11'h100, 16'h8010, 1, 0, 16'd2));
    vecs.push_back(mkVec(1, 13'h0104, 13'h0014, 1, 1, 13'h0105, 13'h0015, 1, 0, 1, 11'h101, 16'h8011, 0, 0, 16'd2));
    vecs.push_back(mkVec(1, 13'h0106, 13'h0016, 1, 1, 13'h0107, 13'h0017, 1, 0, 1, 11'h102, 16'h8012, 1, 0, 16'd4));
    vecs.push_back(mkVec(1, 13'h0108, 13'h0018, 1, 1, 13'h0109, 13'h0019, 1, 0, 1, 11'h103, 16'h8013, 0, 0, 16'd4));
    vecs.push_back(mkVec(1, 13'h010A, 13'h001A, 1, 1, 13'h010B, 13'h001B, 1, 0, 1, 11'h106, 16'h8016, 1, 0, 16'd6));
    vecs.push_back(idleVec(1, 11'h107, 16'h8017, 0, 0, 16'd6));
    vecs.push_back(idleVec(1, 11'h10A, 16'h801A, 1, 0, 16'd6));
    vecs.push_back(idleVec(1, 11'h10B, 16'h801B, 1, 0, 16'd6));
    vecs.push_back(idleVec(0, 11'h0, 16'h0, 1, 0, 16'd6));

    // Reset held with flush and updates active, then the full power-on clear.
    @(posedge CLK);
    rstCycle(16'd0);
    rstCycle(16'd0);
    for (int i = 0; i < 2048; i++) clearCycle(i, (i <= 5) ? 16'd0 : 16'd2, i == 5, i == 5, 1'b0);

    for (int i = 0; i < vecs.size(); i++) step($sformatf("row%0d", i), vecs[i]);

    // Flush with three entries queued: none of them may reach the table.
    step("flush_q0", mkVec(1, 13'h0200, 13'h0020, 1, 1, 13'h0201, 13'h0021, 1, 0, 0, 11'h0, 16'h0, 1, 0, 16'd6));
    step("flush_q1", mkVec(1, 13'h0202, 13'h0022, 1, 1, 13'h0203, 13'h0023, 1, 0, 1, 11'h200, 16'h8020, 1, 0, 16'd6));
    step("flush_req", mkVec(1, 13'h0204, 13'h0024, 1, 0, 13'h0, 13'h0, 0, 1, 0, 11'h0, 16'h0, 0, 0, 16'd6));
    for (int i = 0; i < 2048; i++) clearCycle(i, (i <= 10) ? 16'd7 : 16'd9, i == 10, i == 10, 1'b0);
    step("after_flush", idleVec(0, 11'h0, 16'h0, 1, 0, 16'd9));

    // Flush while ready: both updates become drops; then flush mid-clear and reset mid-clear.
    step("flush_ready", mkVec(1, 13'h0300, 13'h0030, 1, 1, 13'h0301, 13'h0031, 1, 1, 0, 11'h0, 16'h0, 1, 0, 16'd9));
    for (int i = 0; i <= 500; i++) clearCycle(i, 16'd11, 1'b0, 1'b0, i == 500);
    for (int i = 0; i < 1000; i++) clearCycle(i, 16'd11, 1'b0, 1'b0, 1'b0);
    rstCycle(16'd11);
    for (int i = 0; i < 2048; i++) clearCycle(i, 16'd0, 1'b0, 1'b0, 1'b0);
    step("after_reset", idleVec(0, 11'h0, 16'h0, 1, 0, 16'd0));

    // Flush held with both pipes valid keeps restarting the clear; drop_cnt saturates.
    step("sat_start", mkVec(1, 13'h0400, 13'h0040, 1, 1, 13'h0401, 13'h0041, 1, 1, 0, 11'h0, 16'h0, 1, 0, 16'd0));
    for (int k = 1; k <= 32769; k++) begin
      int d;
      d = (2 * k > 65535) ? 65535 : 2 * k;
      clearCycle(0, 16'(d), 1'b1, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule
